// File: rtl/pe_array_pkg.sv
// ============================================================================
// Module   : pe_array_pkg
// Brief    : bfloat16 field widths, bias, special constants and field struct.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_array_pkg;

    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;
    localparam int BF16_BIAS  = 127;

    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [15:0] BF16_POS_INF = 16'h7F80;

    typedef struct packed {
        logic                  sign;
        logic [BF16_EXP_W-1:0] exp;
        logic [BF16_MAN_W-1:0] man;
    } bf16_t;

endpackage

`default_nettype wire

// File: rtl/pe_bf16_mul.sv
// ============================================================================
// Module   : pe_bf16_mul
// Brief    : Combinational single-lane bfloat16 multiplier, subnormals flushed,
//            round to nearest even, no subnormal outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_bf16_mul
    import pe_array_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);

    bf16_t fa;
    bf16_t fb;

    assign fa = bf16_t'(a);
    assign fb = bf16_t'(b);

    logic        sign;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic [15:0] prod;
    logic [9:0]  exp_norm;
    logic [6:0]  mant_sel;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [7:0]  mant_rnd;
    logic [9:0]  exp_fin;

    always_comb begin
        sign     = fa.sign ^ fb.sign;
        a_nan    = (&fa.exp) && (|fa.man);
        b_nan    = (&fb.exp) && (|fb.man);
        a_inf    = (&fa.exp) && !(|fa.man);
        b_inf    = (&fb.exp) && !(|fb.man);
        // Exponent 0 covers both true zero and subnormals (flush to zero).
        a_zero   = !(|fa.exp);
        b_zero   = !(|fb.exp);

        prod     = 16'({1'b1, fa.man}) * 16'({1'b1, fb.man});
        exp_norm = 10'({2'b00, fa.exp}) + 10'({2'b00, fb.exp})
                 - 10'(BF16_BIAS) + {9'b0, prod[15]};
        mant_sel = prod[15] ? prod[14:8] : prod[13:7];
        guard    = prod[15] ? prod[7]    : prod[6];
        sticky   = prod[15] ? (|prod[6:0]) : (|prod[5:0]);
        round_up = guard & (sticky | mant_sel[0]);

        // A carry out of the rounded mantissa leaves bits [6:0] zero, which is
        // exactly the renormalised 1.0 mantissa; only the exponent needs a bump.
        mant_rnd = {1'b0, mant_sel} + {7'b0, round_up};
        exp_fin  = exp_norm + {9'b0, mant_rnd[7]};

        p = {sign, exp_fin[7:0], mant_rnd[6:0]};
        if (a_nan || b_nan) begin
            p = BF16_QNAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            p = BF16_QNAN;
        end else if (a_inf || b_inf) begin
            p = {sign, BF16_POS_INF[14:0]};
        end else if (a_zero || b_zero) begin
            p = {sign, 15'b0};
        end else if ($signed(exp_fin) >= 10'sd255) begin
            p = {sign, BF16_POS_INF[14:0]};
        end else if ($signed(exp_fin) <= 10'sd0) begin
            p = {sign, 15'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/pe_array_top.sv
// ============================================================================
// Module   : pe_array_top
// Brief    : Lane-parallel bfloat16 multiplier array with registered outputs.
//            Define PE_ARRAY_INPUT_REG_EN to register A/B/in_valid (latency 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_array_top
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_SIZE = 128,
    parameter int ROW_SIZE   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] A,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] B,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] Mul,
    output logic                             out_valid
);

    localparam int BUS_W    = DATA_WIDTH * ARRAY_SIZE;
    localparam int NUM_ROWS = ARRAY_SIZE / ROW_SIZE;

    logic [BUS_W-1:0] a_mul;
    logic [BUS_W-1:0] b_mul;
    logic             valid_mul;
    logic [BUS_W-1:0] prod;

`ifdef PE_ARRAY_INPUT_REG_EN
    logic [BUS_W-1:0] r_a;
    logic [BUS_W-1:0] r_b;
    logic             r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_a     <= A;
            r_b     <= B;
            r_valid <= in_valid;
        end
    end

    assign a_mul     = r_a;
    assign b_mul     = r_b;
    assign valid_mul = r_valid;
`else
    assign a_mul     = A;
    assign b_mul     = B;
    assign valid_mul = in_valid;
`endif

    // Lane 0 sits in the MSB slice of every bus.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar l = 0; l < ROW_SIZE; l++) begin : g_lane
            localparam int LANE = r * ROW_SIZE + l;
            localparam int HI   = (ARRAY_SIZE - LANE) * DATA_WIDTH - 1;

            pe_bf16_mul u_pe (
                .a (a_mul[HI -: DATA_WIDTH]),
                .b (b_mul[HI -: DATA_WIDTH]),
                .p (prod [HI -: DATA_WIDTH])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Mul       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid_mul;
            if (valid_mul) begin
                Mul <= prod;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pe_array_top.sv
// ============================================================================
// Module   : tb_pe_array_top
// Brief    : Self-checking bench for pe_array_top against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_array_top;

    localparam int N = 128;
    localparam int W = 16 * N;
`ifdef PE_ARRAY_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Mul;
    logic         out_valid;

    int checks;
    int errors;

    pe_array_top #(
        .DATA_WIDTH (16),
        .ARRAY_SIZE (N),
        .ROW_SIZE   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Mul       (Mul),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lane_of(input logic [W-1:0] v, input int i);
        return v[(N - i) * 16 - 1 -: 16];
    endfunction

    function automatic logic [W-1:0] put_lane(input logic [W-1:0] v, input int i,
                                              input logic [15:0] x);
        logic [W-1:0] t;
        t = v;
        t[(N - i) * 16 - 1 -: 16] = x;
        return t;
    endfunction

    // Reference: exact integer significand product, then round by remainder.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int   ea, eb, ma, mb, p, e, sh, q, rem, half;
        logic [15:0] r;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        ma = int'(a[6:0]);
        mb = int'(b[6:0]);
        if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return 16'h7FC0;
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 16'h7FC0;
        if (ea == 255 || eb == 255) return {s, 15'h7F80};
        if (ea == 0 || eb == 0) return {s, 15'h0};
        p = (128 + ma) * (128 + mb);
        e = ea + eb - 127;
        if (p >= 32768) begin
            sh = 8;
            e  = e + 1;
        end else begin
            sh = 7;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q >= 256) begin
            q = q / 2;
            e = e + 1;
        end
        if (e >= 255) return {s, 15'h7F80};
        if (e <= 0) return {s, 15'h0};
        r = {s, e[7:0], q[6:0]};
        return r;
    endfunction

    function automatic logic [W-1:0] ref_vec(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r = put_lane(r, i, ref_mul(lane_of(a, i), lane_of(b, i)));
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec(input bit normal_only);
        logic [W-1:0] r;
        logic [15:0]  x;
        r = '0;
        for (int i = 0; i < N; i++) begin
            x = 16'($urandom);
            if (normal_only) x[14:7] = 8'($urandom_range(100, 154));
            r = put_lane(r, i, x);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] fill(input logic [15:0] x);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r = put_lane(r, i, x);
        return r;
    endfunction

    // Drives one valid vector; returns at the negedge where its result is visible.
    task automatic apply_vec(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [W-1:0] a, b, e;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = rand_vec(1'b1);
        B        = rand_vec(1'b1);
        #2;
        checks++;
        if (Mul !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: Mul_lane0=%h out_valid=%b, want 0000/0", lane_of(Mul, 0), out_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (Mul !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: Mul_lane0=%h out_valid=%b, want 0000/0", lane_of(Mul, 0), out_valid);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: out_valid=%b want 0", out_valid);
        end

        // Valid data in flight, then an asynchronous reset between edges.
        in_valid = 1'b1;
        A        = rand_vec(1'b1);
        B        = rand_vec(1'b1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Mul !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: Mul_lane0=%h out_valid=%b, want 0000/0", lane_of(Mul, 0), out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || Mul !== '0) begin
            errors++;
            $display("FAIL reset_discard: out_valid=%b Mul_lane0=%h, want 0/0000", out_valid, lane_of(Mul, 0));
        end

        a = rand_vec(1'b1);
        b = rand_vec(1'b1);
        e = ref_vec(a, b);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            checks++;
            if (out_valid !== (k == LAT)) begin
                errors++;
                $display("FAIL reset_first_latency k=%0d: out_valid=%b want %b", k, out_valid, (k == LAT));
            end
            if (k == LAT) begin
                checks++;
                if (Mul !== e) begin
                    errors++;
                    $display("FAIL reset_first_data: lane0 got %h want %h", lane_of(Mul, 0), lane_of(e, 0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        apply_vec(fill(16'h3F80), fill(16'h4000));
        checks++;
        if (Mul !== fill(16'h4000) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic: lane0 got %h want 4000 out_valid=%b", lane_of(Mul, 0), out_valid);
        end
    endtask

    task automatic test_lane_mix();
        logic [W-1:0] a, b, e;
        a = put_lane(put_lane(put_lane(fill(16'h3F80), 0, 16'h3FC0), 1, 16'hC040), 127, 16'h0000);
        b = put_lane(put_lane(put_lane(fill(16'h3F80), 0, 16'h3FC0), 1, 16'h4000), 127, 16'hC000);
        e = put_lane(put_lane(put_lane(fill(16'h3F80), 0, 16'h4010), 1, 16'hC0C0), 127, 16'h8000);
        apply_vec(a, b);
        checks++;
        if (lane_of(Mul, 0) !== 16'h4010) begin
            errors++;
            $display("FAIL mix_lane0: got %h want 4010", lane_of(Mul, 0));
        end
        checks++;
        if (lane_of(Mul, 1) !== 16'hC0C0) begin
            errors++;
            $display("FAIL mix_lane1: got %h want c0c0", lane_of(Mul, 1));
        end
        checks++;
        if (lane_of(Mul, 127) !== 16'h8000) begin
            errors++;
            $display("FAIL mix_lane127: got %h want 8000", lane_of(Mul, 127));
        end
        checks++;
        if (Mul !== e) begin
            errors++;
            $display("FAIL mix_bus: lane2 got %h want 3f80", lane_of(Mul, 2));
        end
    endtask

    task automatic test_specials();
        logic [15:0] sa [6];
        logic [15:0] sb [6];
        logic [15:0] se [6];
        logic [W-1:0] a, b;
        sa = '{16'h7F7F, 16'h7F80, 16'h7FC1, 16'h0001, 16'h0080, 16'h3F81};
        sb = '{16'h4000, 16'h0000, 16'h3F80, 16'h4000, 16'h3F00, 16'h3F81};
        se = '{16'h7F80, 16'h7FC0, 16'h7FC0, 16'h0000, 16'h0000, 16'h3F82};
        a = rand_vec(1'b1);
        b = rand_vec(1'b1);
        for (int i = 0; i < 6; i++) begin
            a = put_lane(a, 10 + i * 19, sa[i]);
            b = put_lane(b, 10 + i * 19, sb[i]);
        end
        apply_vec(a, b);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (lane_of(Mul, 10 + i * 19) !== se[i]) begin
                errors++;
                $display("FAIL special_%0d (%h x %h): got %h want %h", i, sa[i], sb[i],
                         lane_of(Mul, 10 + i * 19), se[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, e;
        for (int v = 0; v < 24; v++) begin
            a = rand_vec(v % 2 == 0);
            b = rand_vec(v % 3 == 0);
            e = ref_vec(a, b);
            apply_vec(a, b);
            checks++;
            if (Mul !== e) begin
                errors++;
                for (int i = 0; i < N; i++) begin
                    if (lane_of(Mul, i) !== lane_of(e, i)) begin
                        $display("FAIL random_vec%0d lane%0d (%h x %h): got %h want %h", v, i,
                                 lane_of(a, i), lane_of(b, i), lane_of(Mul, i), lane_of(e, i));
                        break;
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [10];
        logic [W-1:0] vb [10];
        logic [W-1:0] ve [10];
        for (int k = 0; k < 10; k++) begin
            va[k] = rand_vec(1'b1);
            vb[k] = rand_vec(1'b1);
            ve[k] = ref_vec(va[k], vb[k]);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 10 + LAT; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (c >= LAT)) begin
                errors++;
                $display("FAIL b2b_valid cycle%0d: out_valid=%b want %b", c, out_valid, (c >= LAT));
            end
            if (c >= LAT) begin
                checks++;
                if (Mul !== ve[c - LAT]) begin
                    errors++;
                    $display("FAIL b2b_data idx%0d: lane0 got %h want %h", c - LAT,
                             lane_of(Mul, 0), lane_of(ve[c - LAT], 0));
                end
            end
            if (c < 10) begin
                A        = va[c];
                B        = vb[c];
                in_valid = 1'b1;
            end else begin
                A        = rand_vec(1'b0);
                B        = rand_vec(1'b0);
                in_valid = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || Mul !== ve[9]) begin
                errors++;
                $display("FAIL hold: out_valid=%b lane0 got %h want 0/%h", out_valid,
                         lane_of(Mul, 0), lane_of(ve[9], 0));
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        test_reset();
        test_basic();
        test_lane_mix();
        test_specials();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pe_array_top.md
# pe_array_top

Lane-parallel bfloat16 multiplier array: multiplies ARRAY_SIZE operand pairs element-wise and returns ARRAY_SIZE bfloat16 products on a packed bus. It is the multiply stage of the matmul datapath, feeding the downstream reduction tree. PEs are grouped in rows of ROW_SIZE lanes for placement; the rows share no arithmetic.

## Interface
- DATA_WIDTH, 16: lane width; fixed at 16 (bfloat16); other values are unsupported.
- ARRAY_SIZE, 128: number of lanes; must be a multiple of ROW_SIZE.
- ROW_SIZE, 16: lanes per PE row.
- clk  in  1  single clock; all state is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  A/B lanes are valid this cycle.
- A  in  DATA_WIDTH*ARRAY_SIZE  packed operand A; lane i at [(ARRAY_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH], so lane 0 is the MSB slice.
- B  in  DATA_WIDTH*ARRAY_SIZE  packed operand B; same lane packing as A.
- Mul  out  DATA_WIDTH*ARRAY_SIZE  packed products; lane i = A lane i × B lane i, same packing.
- out_valid  out  1  Mul holds a valid result.

## Operation
- Each lane performs an independent bfloat16 multiply: sign 1 bit, exponent 8 bits, bias 127, mantissa 7 bits.
- Sign of the result = sign A XOR sign B. This holds for zero, infinity and overflow results.
- Zero and subnormal inputs are flushed to zero, giving a signed-zero result.
- Special cases:
  - NaN on either input → 0x7FC0.
  - Inf × 0 → 0x7FC0.
  - Inf × nonzero finite → signed Inf.
- Normal path:
  - 8×8 significand product with hidden 1s (16 bits).
  - Exponent = eA + eB − 127; add 1 when product bit 15 is set, then shift to normalise.
  - Round to nearest, ties to even, using guard and sticky bits. A rounding carry renormalises and increments the exponent.
- Final exponent ≥ 255 → signed Inf (0x7F80 / 0xFF80). Final exponent ≤ 0 → signed zero; no subnormal outputs.
- Lanes never interact. There are no stalls and no backpressure: a new vector is accepted every cycle.

## Timing
- Reset values: Mul = 0, out_valid = 0. Both clear immediately on rst_n low, regardless of clk.
- Default latency is 1 cycle. The A/B/in_valid sampled at edge N appear on Mul/out_valid after edge N.
- Mul updates only on cycles where in_valid = 1; otherwise it holds its last value. out_valid follows in_valid with the same latency.
- Reset asserted mid-stream discards all in-flight data. After rst_n deasserts, the first valid result comes from the first in_valid sampled after release.
- Back-to-back in_valid gives one result per cycle in order.

## Configuration
- PE_ARRAY_INPUT_REG_EN defined: A, B and in_valid are registered before the multipliers. Latency becomes 2 cycles. The input registers reset to 0.
- Not defined: the multipliers take A/B directly. Latency is 1 cycle.
- Arithmetic results are identical in both builds.

## Structure
- Package pe_array_pkg holds:
  - bf16 field widths and bias (8, 7, 127).
  - Constants BF16_QNAN = 16'h7FC0 and BF16_POS_INF = 16'h7F80.
  - A packed bf16 struct typedef (sign/exp/man).
- One sub-module, pe_bf16_mul: combinational single-lane multiplier. The top generates ARRAY_SIZE/ROW_SIZE rows of ROW_SIZE instances, then registers the outputs.

## Test plan
- Reset: rst_n low with random A/B and in_valid = 1 → Mul = 0 and out_valid = 0. Release rst_n → first result 1 cycle after the next in_valid (2 with PE_ARRAY_INPUT_REG_EN).
- Basic products: all lanes A = 0x3F80 (1.0), B = 0x4000 (2.0) → every lane 0x4000.
- Per-lane mix:
  - lane 0: 0x3FC0 × 0x3FC0 → 0x4010 (2.25).
  - lane 1: 0xC040 × 0x4000 → 0xC0C0 (−6.0).
  - lane 127: 0x0000 × 0xC000 → 0x8000.
  - Checks that lane packing and MSB-first order are correct.
- Specials:
  - 0x7F7F × 0x4000 → 0x7F80.
  - 0x7F80 × 0x0000 → 0x7FC0.
  - 0x7FC1 × 0x3F80 → 0x7FC0.
  - 0x0001 × 0x4000 → 0x0000.
  - 0x0080 × 0x3F00 → 0x0000 (underflow).
- Rounding: 0x3F81 × 0x3F81 → 0x3F82, the exact product rounded to nearest even. A random 128-lane vector is compared against a golden software model, bit-exact.
- Throughput/hold: 10 back-to-back vectors → 10 consecutive out_valid cycles in order. Then drop in_valid → Mul holds its last value and out_valid = 0.
